// File: rtl/bch_err_correct.sv
// BCH decoder final stage: latches the codeword and Chien error vector, counts errors
// against the locator degree, streams the corrected word out. Option: BCH_CORR_RAW_ON_FAIL_EN.
module bch_err_correct #(
  parameter int N_MAX = 1023,
  parameter int T_MAX = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       n,
  input  logic [3:0]       degree,
  input  logic [N_MAX-1:0] rx_cw,
  input  logic [N_MAX-1:0] err_vec,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             fail,
  output logic [3:0]       err_cnt
);
  localparam int LOG_W = $clog2(OUT_W);
  localparam int NW    = (N_MAX + OUT_W - 1) / OUT_W;
  localparam int PADW  = NW * OUT_W;
  localparam int IW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int KW    = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, COUNT, EMIT, DONE} state_t;

  state_t                   state;
  logic [NW-1:0][OUT_W-1:0] rx_q, err_q;
  logic [KW-1:0]            w_q, w_in;
  logic [IW-1:0]            k, nxt_idx;
  logic [3:0]               deg_q, cnt, cnt_nxt;
  logic [N_MAX-1:0]         msk;
  logic [10:0]              n_rnd;
  logic                     last_chunk, fail_nxt;
  logic [OUT_W-1:0]         nxt_word;
  int                       pc_sum;

  function automatic int popcnt(input logic [OUT_W-1:0] v);
    popcnt = 0;
    for (int j = 0; j < OUT_W; j++)
      if (v[j]) popcnt++;
  endfunction

  // Positions >= n are zeroed at capture so counting and output never see them.
  for (genvar i = 0; i < N_MAX; i++) begin : g_msk
    assign msk[i] = (n > 10'(i));
  end

  assign n_rnd = {1'b0, n} + 11'(OUT_W - 1);
  assign w_in  = KW'(n_rnd >> LOG_W);

  always_comb begin
    pc_sum  = 0;
    pc_sum  = int'(cnt) + popcnt(err_q[k]);
    cnt_nxt = (pc_sum > 15) ? 4'd15 : 4'(pc_sum);
  end

  assign last_chunk = (KW'(k) == w_q - 1'b1);
  assign fail_nxt   = (cnt_nxt != deg_q) || (int'(deg_q) > T_MAX);
  assign nxt_idx    = (state == EMIT) ? k + 1'b1 : '0;

`ifdef BCH_CORR_RAW_ON_FAIL_EN
  logic raw_sel;
  // Word 0 is loaded in the same cycle fail is decided, so use the fresh value there.
  assign raw_sel  = (state == EMIT) ? fail : fail_nxt;
  assign nxt_word = raw_sel ? rx_q[nxt_idx] : (rx_q[nxt_idx] ^ err_q[nxt_idx]);
`else
  assign nxt_word = rx_q[nxt_idx] ^ err_q[nxt_idx];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      err_cnt   <= '0;
      k         <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rx_q    <= PADW'(rx_cw & msk);
          err_q   <= PADW'(err_vec & msk);
          w_q     <= w_in;
          deg_q   <= degree;
          k       <= '0;
          cnt     <= '0;
          fail    <= 1'b0;
          err_cnt <= '0;
          busy    <= 1'b1;
          state   <= COUNT;
        end
        COUNT: begin
          if (w_q == '0) begin
            fail  <= (deg_q != 4'd0);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt_nxt;
            k   <= k + 1'b1;
            if (last_chunk) begin
              fail      <= fail_nxt;
              err_cnt   <= cnt_nxt;
              k         <= '0;
              out_valid <= 1'b1;
              out_data  <= nxt_word;
              out_last  <= (w_q == KW'(1));
              state     <= EMIT;
            end
          end
        end
        EMIT: if (out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            k        <= nxt_idx;
            out_data <= nxt_word;
            out_last <= (KW'(nxt_idx) == w_q - 1'b1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bch_err_correct.sv
// Self-checking bench for bch_err_correct: directed cases plus randomized decodes
// against a bit-position reference model.
module tb_bch_err_correct;
  logic          clk = 1'b0, rst, start, out_ready;
  logic [9:0]    n;
  logic [3:0]    degree;
  logic [1022:0] rx_cw, err_vec;
  logic          busy, out_valid, out_last, done, fail;
  logic [7:0]    out_data;
  logic [3:0]    err_cnt;
  int            vectors = 0, miscompares = 0;

`ifdef BCH_CORR_RAW_ON_FAIL_EN
  localparam bit RAW = 1'b1;
`else
  localparam bit RAW = 1'b0;
`endif

  bch_err_correct dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .degree(degree),
    .rx_cw(rx_cw), .err_vec(err_vec), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .fail(fail), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_errcnt"}, err_cnt, 0);
  endtask

  // mode: 0 ready held high (timing checked), 1 ready toggles, 2 ready random
  task automatic run_decode(input int nn, input int dg, input logic [1022:0] rxv,
                            input logic [1022:0] errv, input int mode);
    logic [7:0] exp_w[$];
    int ec, w, hs, cyc, first_v, done_cyc;
    logic ef, rdy, stall_prev, prev_l;
    logic [7:0] prev_d;
    ec = 0;
    for (int i = 0; i < nn; i++) if (errv[i]) ec++;
    if (ec > 15) ec = 15;
    ef = (ec != dg) || (dg > 4);
    w = (nn + 7) / 8;
    for (int q = 0; q < w; q++) begin
      logic [7:0] b;
      b = '0;
      for (int j = 0; j < 8; j++)
        if (q * 8 + j < nn) b[j] = rxv[q*8+j] ^ (errv[q*8+j] & !(RAW && ef));
      exp_w.push_back(b);
    end

    start = 1'b1; n = nn[9:0]; degree = dg[3:0]; rx_cw = rxv; err_vec = errv;
    out_ready = 1'b0;
    tick();
    start = 1'b0; cyc = 1;
    chk("busy_rise", busy, 1);
    hs = 0; first_v = -1; done_cyc = -1; stall_prev = 1'b0; prev_d = '0; prev_l = 1'b0;
    while (cyc < 2000) begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_last", out_last, prev_l);
      end
      if (done) begin done_cyc = cyc; break; end
      chk("busy_hold", busy, 1);
      if (out_valid && first_v < 0) first_v = cyc;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk("word_data", out_data, (hs < w) ? exp_w[hs] : 8'hxx);
        chk("word_last", out_last, hs == w - 1);
        hs++;
      end
      stall_prev = out_valid && !rdy; prev_d = out_data; prev_l = out_last;
      tick(); cyc++;
    end
    out_ready = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    chk("handshakes", hs, w);
    chk("fail", fail, ef);
    chk("err_cnt", err_cnt, ec);
    if (mode == 0) begin
      chk("done_cycle", done_cyc, (w == 0) ? 2 : 2 * w + 1);
      chk("first_valid", first_v, (w == 0) ? -1 : w + 1);
    end
    tick();
    chk("done_pulse", done, 0);
    chk("busy_fall", busy, 0);
    chk("fail_held", fail, ef);
    chk("errcnt_held", err_cnt, ec);
  endtask

  initial begin
    logic [1022:0] rxv, errv;
    int nn, dg, ne;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; n = '0; degree = '0;
    rx_cw = '0; err_vec = '0;
    tick(); tick(); tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // basic decode, degree matches
    errv = '0; errv[3] = 1'b1; errv[12] = 1'b1;
    run_decode(15, 2, '0, errv, 0);
    // degree mismatch
    run_decode(15, 3, '0, errv, 0);
    // error above n is masked
    errv = '0; errv[14] = 1'b1; errv[20] = 1'b1;
    run_decode(15, 1, '0, errv, 0);
    // backpressure toggling
    errv = '0; errv[3] = 1'b1; errv[12] = 1'b1;
    run_decode(15, 2, '0, errv, 1);

    // reset in the cycle after the first handshake
    start = 1'b1; n = 10'd15; degree = 4'd2; rx_cw = '0; err_vec = errv; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("rst_mid_word0_valid", out_valid, 1);
    chk("rst_mid_word0_data", out_data, 8'h08);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk_idle_outputs("rst_mid");
    tick();
    chk("rst_mid_no_done", done, 0);
    run_decode(15, 2, '0, errv, 0);

    // start together with rst: rst wins
    rst = 1'b1; start = 1'b1; n = 10'd15;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    tick();
    chk("rst_start_busy2", busy, 0);
    chk("rst_start_valid", out_valid, 0);

    // n == 0 with an ignored second start while busy
    start = 1'b1; n = 10'd0; degree = 4'd0; err_vec = '0;
    tick();
    n = 10'd15; degree = 4'd3; err_vec[0] = 1'b1;
    chk("n0_busy", busy, 1);
    chk("n0_valid_c1", out_valid, 0);
    tick();
    start = 1'b0;
    chk("n0_done_c2", done, 1);
    chk("n0_fail", fail, 0);
    chk("n0_errcnt", err_cnt, 0);
    chk("n0_valid_c2", out_valid, 0);
    tick();
    chk("n0_busy_fall", busy, 0);
    chk("n0_done_once", done, 0);
    tick();
    chk("n0_ignored_start", busy, 0);
    chk("n0_ignored_valid", out_valid, 0);
    run_decode(0, 2, '0, '0, 0);

    // saturation: 20 located errors
    errv = '0;
    for (int i = 0; i < 20; i++) errv[i*7] = 1'b1;
    run_decode(200, 15, '0, errv, 0);

    // full length, four errors, random data
    for (int i = 0; i < 1023; i++) rxv[i] = 1'($urandom_range(0, 1));
    errv = '0; errv[0] = 1'b1; errv[511] = 1'b1; errv[777] = 1'b1; errv[1022] = 1'b1;
    run_decode(1023, 4, rxv, errv, 2);

    for (int t = 0; t < 20; t++) begin
      nn = (t % 5 == 0) ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 1023));
      for (int i = 0; i < 1023; i++) rxv[i] = 1'($urandom_range(0, 1));
      errv = '0;
      ne = $urandom_range(0, 6);
      for (int e = 0; e < ne; e++)
        errv[$urandom_range(0, (nn + 9 > 1022) ? 1022 : nn + 9)] = 1'b1;
      dg = ($urandom_range(0, 1) == 1) ? ne : int'($urandom_range(0, 7));
      run_decode(nn, dg, rxv, errv, t % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
